// File: rtl/que_sched.sv
// -----------------------------------------------------------------------------
// que_sched
//
// Round-robin scheduler that funnels NUM_REQ producer streams into an external
// queue and passes the queue head straight through to a single consumer.
// A health monitor can interrupt operation: an intermittent failure clears the
// queue and holds everything off for FLUSH_CYCLES cycles, a permanent failure
// locks the block until reset.
//
// Optional feature (compile-time macro QUE_SCHED_STATS_EN):
//   defined   -> flush_count counts RUN->FLUSH and RUN->LOCK transitions,
//                saturating at 16'hFFFF
//   undefined -> flush_count is tied to zero, no counter is built
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   inter_fail          intermittent health-test failure pulse
//   perm_fail           permanent health-test failure
//   req_valid/req_data  per-producer word available / words (i at [i*WIDTH+:WIDTH])
//   req_ready           one-hot grant back to the producers
//   fifo_wdata/enque    queue write port
//   fifo_deque/flush    queue pop / clear
//   fifo_rdata          queue head, valid in the dequeue cycle
//   fifo_full/empty     queue status
//   out_valid/ready/data consumer handshake (combinational pass-through)
//   locked              permanent-failure lockout indicator
//   flush_count         flush-event counter
// -----------------------------------------------------------------------------
module que_sched #(
  parameter int NUM_REQ      = 2,
  parameter int WIDTH        = 256,
  parameter int FLUSH_CYCLES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     inter_fail,
  input  logic                     perm_fail,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [WIDTH-1:0]         fifo_wdata,
  output logic                     fifo_enque,
  output logic                     fifo_deque,
  output logic                     fifo_flush,
  input  logic [WIDTH-1:0]         fifo_rdata,
  input  logic                     fifo_full,
  input  logic                     fifo_empty,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     locked,
  output logic [15:0]              flush_count
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_FLUSH = 2'd1,
    S_LOCK  = 2'd2
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] last_grant;
  logic [7:0]       flush_left;

  logic             active;
  logic             gnt_found;
  logic [IDX_W-1:0] gnt_idx;
  logic             grant_en;

  // Traffic may move only in a clean RUN cycle: any reset or failure seen this
  // cycle already blocks grants and dequeues and clears the queue.
  always_comb begin
    active = (state == S_RUN) && !rst && !inter_fail && !perm_fail;
  end

  // Round-robin search starting one past the last granted producer.
  always_comb begin
    int cand;
    cand      = 0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = (int'(last_grant) + i) % NUM_REQ;
      if (!gnt_found && req_valid[IDX_W'(cand)]) begin
        gnt_found = 1'b1;
        gnt_idx   = IDX_W'(cand);
      end
    end
  end

  // A full queue blocks enqueue even if a dequeue frees a slot this cycle.
  always_comb begin
    grant_en = active && !fifo_full && gnt_found;
  end

  always_comb begin
    req_ready  = '0;
    fifo_wdata = '0;
    if (grant_en) begin
      req_ready = NUM_REQ'(1) << gnt_idx;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (gnt_idx == IDX_W'(i)) begin
          fifo_wdata = req_data[i*WIDTH +: WIDTH];
        end
      end
    end
  end

  assign fifo_enque = grant_en;
  assign out_valid  = active && !fifo_empty;
  assign fifo_deque = out_valid && out_ready;
  assign out_data   = fifo_rdata;
  assign fifo_flush = !active;
  assign locked     = (state == S_LOCK);

  // Reset beats permanent failure, which beats intermittent failure.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_RUN;
      last_grant <= IDX_W'(NUM_REQ - 1);
      flush_left <= '0;
    end else if (perm_fail) begin
      state      <= S_LOCK;
      flush_left <= '0;
    end else if (inter_fail && (state != S_LOCK)) begin
      state      <= S_FLUSH;
      flush_left <= 8'(FLUSH_CYCLES);
    end else begin
      case (state)
        S_FLUSH: begin
          if (flush_left <= 8'd1) begin
            // Leaving flush restarts arbitration at producer 0.
            state      <= S_RUN;
            flush_left <= '0;
            last_grant <= IDX_W'(NUM_REQ - 1);
          end else begin
            flush_left <= flush_left - 8'd1;
          end
        end
        S_RUN: begin
          if (grant_en) begin
            last_grant <= gnt_idx;
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef QUE_SCHED_STATS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] flush_count_q;

  // Only transitions out of RUN are counted; re-flushes and lock from FLUSH
  // are part of an event already counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      flush_count_q <= '0;
    end else if ((state == S_RUN) && (perm_fail || inter_fail)) begin
      flush_count_q <= sat_inc16(flush_count_q);
    end
  end

  assign flush_count = flush_count_q;
`else
  assign flush_count = 16'h0000;
`endif

endmodule

// File: tb/tb_que_sched.sv
module tb_que_sched;

  localparam int N     = 2;
  localparam int W     = 64;
  localparam int F     = 4;
  localparam int DEPTH = 8;

  localparam int ST_RUN   = 0;
  localparam int ST_FLUSH = 1;
  localparam int ST_LOCK  = 2;

`ifdef QUE_SCHED_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic             inter_fail;
  logic             perm_fail;
  logic [N-1:0]     req_valid;
  logic [N*W-1:0]   req_data;
  logic [N-1:0]     req_ready;
  logic [W-1:0]     fifo_wdata;
  logic             fifo_enque;
  logic             fifo_deque;
  logic             fifo_flush;
  logic [W-1:0]     fifo_rdata;
  logic             fifo_full;
  logic             fifo_empty;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_data;
  logic             locked;
  logic [15:0]      flush_count;

  que_sched #(
    .NUM_REQ      (N),
    .WIDTH        (W),
    .FLUSH_CYCLES (F)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .inter_fail  (inter_fail),
    .perm_fail   (perm_fail),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .fifo_wdata  (fifo_wdata),
    .fifo_enque  (fifo_enque),
    .fifo_deque  (fifo_deque),
    .fifo_flush  (fifo_flush),
    .fifo_rdata  (fifo_rdata),
    .fifo_full   (fifo_full),
    .fifo_empty  (fifo_empty),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .locked      (locked),
    .flush_count (flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: scheduler mode, round-robin pointer, remaining flush
  // cycles, event count and the contents of the external queue.
  int           m_st;
  int           m_last;
  int           m_left;
  int           m_cnt;
  bit           m_known;
  logic [W-1:0] mq[$];

  int checks;
  int failures;

  // DUT outputs as seen in the most recent cycle.
  logic [N-1:0] s_ready;
  logic         s_enq;
  logic         s_deq;
  logic         s_ov;
  logic         s_flush;
  logic         s_locked;
  logic [W-1:0] s_odata;
  logic [15:0]  s_fc;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] word_of(input int i);
    return W'(req_data >> (i * W));
  endfunction

  // One clock cycle: present queue status, check outputs mid-cycle against the
  // model, then advance model and queue at the rising edge.
  task automatic step();
    bit           act;
    int           gi;
    int           c;
    logic [N-1:0] eg;
    bit           e_ov;
    bit           e_deq;
    fifo_full  = (mq.size() >= DEPTH);
    fifo_empty = (mq.size() == 0);
    fifo_rdata = (mq.size() == 0) ? '0 : mq[0];
    @(negedge clk);
    act = !rst && !inter_fail && !perm_fail && m_known && (m_st == ST_RUN);
    gi  = -1;
    if (act && mq.size() < DEPTH) begin
      for (int k = 1; k <= N; k++) begin
        c = (m_last + k) % N;
        if (gi < 0 && ((req_valid >> c) & N'(1)) != '0) gi = c;
      end
    end
    eg    = (gi >= 0) ? (N'(1) << gi) : '0;
    e_ov  = act && (mq.size() > 0);
    e_deq = e_ov && out_ready;

    s_ready  = req_ready;
    s_enq    = fifo_enque;
    s_deq    = fifo_deque;
    s_ov     = out_valid;
    s_flush  = fifo_flush;
    s_locked = locked;
    s_odata  = out_data;
    s_fc     = flush_count;

    chk("req_ready", W'(req_ready), W'(eg));
    chk("fifo_enque", W'(fifo_enque), W'(gi >= 0));
    if (gi >= 0) chk("fifo_wdata", fifo_wdata, word_of(gi));
    chk("out_valid", W'(out_valid), W'(e_ov));
    chk("fifo_deque", W'(fifo_deque), W'(e_deq));
    if (e_deq) chk("out_data", out_data, mq[0]);
    chk("fifo_flush", W'(fifo_flush), W'(!act));
    if (m_known) begin
      chk("locked", W'(locked), W'(m_st == ST_LOCK));
      chk("flush_count", W'(flush_count), W'(STATS ? m_cnt : 0));
    end

    @(posedge clk);
    if (!act) begin
      mq.delete();
    end else begin
      if (e_deq) void'(mq.pop_front());
      if (gi >= 0) mq.push_back(word_of(gi));
    end
    if (rst) begin
      m_st = ST_RUN; m_last = N - 1; m_left = 0; m_cnt = 0; m_known = 1'b1;
    end else if (perm_fail) begin
      if (m_st == ST_RUN && m_cnt < 65535) m_cnt++;
      m_st = ST_LOCK;
    end else if (inter_fail && m_st != ST_LOCK) begin
      if (m_st == ST_RUN && m_cnt < 65535) m_cnt++;
      m_st = ST_FLUSH; m_left = F;
    end else if (m_st == ST_FLUSH) begin
      m_left--;
      if (m_left == 0) begin
        m_st = ST_RUN; m_last = N - 1;
      end
    end else if (gi >= 0) begin
      m_last = gi;
    end
    #1;
  endtask

  task automatic rand_data();
    for (int i = 0; i < N; i++) req_data[i*W +: W] = {$urandom(), $urandom()};
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; failures = 0;
    m_st = ST_RUN; m_last = N - 1; m_left = 0; m_cnt = 0; m_known = 1'b0;
    rst = 1'b1; inter_fail = 1'b0; perm_fail = 1'b0;
    req_valid = '0; req_data = '0; out_ready = 1'b0;
    fifo_full = 1'b0; fifo_empty = 1'b1; fifo_rdata = '0;
    #1;

    // Reset
    step();
    chk("rst_flush", W'(s_flush), W'(1));
    chk("rst_ready", W'(s_ready), W'(0));
    step();
    rst = 1'b0;
    step();
    chk("post_rst_locked", W'(s_locked), W'(0));
    chk("post_rst_fc", W'(s_fc), W'(0));

    // Round-robin with both producers busy
    req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      rand_data();
      step();
      chk("rr_grant", W'(s_ready), (i % 2 == 0) ? W'(1) : W'(2));
      chk("rr_enq", W'(s_enq), W'(1));
    end
    chk("rr_depth", W'(mq.size()), W'(4));

    // Drain
    req_valid = '0; out_ready = 1'b1;
    for (int i = 0; i < 10 && mq.size() > 0; i++) step();
    chk("drain_empty", W'(mq.size()), W'(0));

    // Pass-through: enqueue into empty queue, present next cycle
    req_valid = 2'b01;
    req_data[0 +: W] = {(W/8){8'hA5}};
    step();
    chk("pt_enq", W'(s_enq), W'(1));
    chk("pt_no_ov_same_cycle", W'(s_ov), W'(0));
    req_valid = '0;
    step();
    chk("pt_ov", W'(s_ov), W'(1));
    chk("pt_deq", W'(s_deq), W'(1));
    chk("pt_data", s_odata, {(W/8){8'hA5}});

    // Full queue: dequeue only, then enqueue next cycle
    for (int i = 0; i < DEPTH; i++) mq.push_back({$urandom(), $urandom()});
    req_valid = 2'b01; out_ready = 1'b1;
    rand_data();
    step();
    chk("full_deq", W'(s_deq), W'(1));
    chk("full_no_enq", W'(s_enq), W'(0));
    chk("full_no_grant", W'(s_ready), W'(0));
    step();
    chk("full_then_grant", W'(s_ready), W'(1));
    chk("full_then_enq", W'(s_enq), W'(1));

    // Intermittent failure -> FLUSH for F cycles -> RUN with producer 0 first
    out_ready = 1'b0; req_valid = 2'b11;
    inter_fail = 1'b1;
    step();
    chk("if_flush", W'(s_flush), W'(1));
    chk("if_no_grant", W'(s_ready), W'(0));
    inter_fail = 1'b0;
    for (int i = 0; i < F; i++) begin
      step();
      chk("flush_cycle", W'(s_flush), W'(1));
      chk("flush_no_grant", W'(s_ready), W'(0));
    end
    step();
    chk("flush_exit", W'(s_flush), W'(0));
    chk("flush_exit_grant0", W'(s_ready), W'(1));
    chk("flush_count_1", W'(s_fc), STATS ? W'(1) : W'(0));

    // Reset during FLUSH cycle 2
    inter_fail = 1'b1; step();
    inter_fail = 1'b0; step();
    rst = 1'b1; step();
    rst = 1'b0; step();
    chk("rst_in_flush_run", W'(s_flush), W'(0));
    chk("rst_in_flush_grant", W'(s_ready), W'(1));
    chk("rst_in_flush_fc", W'(s_fc), W'(0));
    step();
    chk("rst_in_flush_grant2", W'(s_ready), W'(2));

    // Permanent + intermittent together -> LOCK until reset
    perm_fail = 1'b1; inter_fail = 1'b1; out_ready = 1'b1;
    step();
    perm_fail = 1'b0; inter_fail = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) inter_fail = 1'b1;
      if (i == 6) inter_fail = 1'b0;
      step();
      chk("lock_no_grant", W'(s_ready), W'(0));
      chk("lock_locked", W'(s_locked), W'(1));
    end
    rst = 1'b1; step();
    rst = 1'b0; step();
    chk("lock_release", W'(s_locked), W'(0));

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      rst        = ($urandom_range(0, 59) == 0);
      perm_fail  = ($urandom_range(0, 99) == 0);
      inter_fail = ($urandom_range(0, 24) == 0);
      req_valid  = N'($urandom());
      out_ready  = ($urandom_range(0, 2) != 0);
      rand_data();
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/que_sched.md
QUE_SCHED -- requirements
Module: que_sched

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2, number of producers (2..8).
REQ-002 SHALL have parameter WIDTH, default 256, data word width.
REQ-003 SHALL have parameter FLUSH_CYCLES, default 4, cycles spent in FLUSH after an intermittent failure (1..255).
REQ-004 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst  in  1  synchronous active-high reset.
REQ-006 SHALL have port inter_fail  in  1  intermittent health-test failure pulse.
REQ-007 SHALL have port perm_fail  in  1  permanent health-test failure.
REQ-008 SHALL have port req_valid  in  NUM_REQ  per-producer word available.
REQ-009 SHALL have port req_data  in  NUM_REQ*WIDTH  producer words, producer i at bits [i*WIDTH +: WIDTH].
REQ-010 SHALL have port req_ready  out  NUM_REQ  one-hot grant; word i accepted when req_valid[i] && req_ready[i].
REQ-011 SHALL have ports fifo_wdata out WIDTH, fifo_enque out 1, fifo_deque out 1, fifo_flush out 1 (queue write data, enqueue, dequeue, queue clear).
REQ-012 SHALL have ports fifo_rdata in WIDTH, fifo_full in 1, fifo_empty in 1 (queue read data, valid in the dequeue cycle; status).
REQ-013 SHALL have ports out_valid out 1, out_ready in 1, out_data out WIDTH (consumer handshake).
REQ-014 SHALL have ports locked out 1 (permanent-failure lockout) and flush_count out 16 (flush-event counter).

Function
REQ-015 SHALL implement states RUN, FLUSH, LOCK; only RUN permits enqueue or dequeue.
REQ-016 SHALL, in RUN with fifo_full=0, grant exactly one valid requester, round-robin starting at index (last_grant+1) mod NUM_REQ; req_ready all zero otherwise.
REQ-017 SHALL drive fifo_enque=1 and fifo_wdata=req_data of the granted requester in the grant cycle, and update last_grant at that clock edge.
REQ-018 SHALL keep fifo_enque=0 when fifo_full=1, even if a dequeue occurs in the same cycle.
REQ-019 SHALL drive out_valid = RUN && !fifo_empty, fifo_deque = out_valid && out_ready, out_data = fifo_rdata combinationally (zero-latency pass-through; out_data is defined only while fifo_deque=1).
REQ-020 SHALL allow simultaneous enqueue and dequeue in one cycle when fifo_full=0 and fifo_empty=0.
REQ-021 SHALL, when fifo_empty=1, keep fifo_deque=0 regardless of out_ready; a word enqueued in cycle N is presentable no earlier than cycle N+1.
REQ-022 SHALL, on inter_fail=1 in RUN or FLUSH (perm_fail=0), enter FLUSH next cycle with a down-counter loaded to FLUSH_CYCLES; inter_fail in FLUSH reloads the counter.
REQ-023 SHALL assert fifo_flush combinationally in the inter_fail cycle and in every FLUSH cycle; req_ready, fifo_enque, fifo_deque, out_valid SHALL be 0 in both.
REQ-024 SHALL return from FLUSH to RUN after exactly FLUSH_CYCLES FLUSH cycles, resetting last_grant to NUM_REQ-1 (so requester 0 has first priority).
REQ-025 SHALL, on perm_fail=1 in any state, enter LOCK next cycle; perm_fail wins over simultaneous inter_fail.
REQ-026 SHALL, in LOCK and in the perm_fail cycle, hold fifo_flush=1, locked=1 (from LOCK), all grants/enqueue/dequeue 0; only rst exits LOCK.
REQ-027 SHALL ignore req_valid changes from a non-granted producer; no word is lost or duplicated across grant boundaries.

Reset
REQ-028 SHALL, while rst=1, force next state RUN, last_grant=NUM_REQ-1, flush counter 0, flush_count 0, and assert fifo_flush=1 with all grants, fifo_enque, fifo_deque, out_valid at 0.
REQ-029 SHALL give rst priority over perm_fail and inter_fail, including mid-FLUSH and in LOCK; locked=0 the cycle after rst.

Configuration
REQ-030 SHALL, with QUE_SCHED_STATS_EN defined, increment flush_count by 1 per RUN-to-FLUSH or RUN-to-LOCK transition, saturating at 16'hFFFF.
REQ-031 SHALL, without QUE_SCHED_STATS_EN, tie flush_count to 16'h0000 and synthesize no counter.

Verification
REQ-032 SHALL test round-robin: NUM_REQ=2, both req_valid=1 for 4 cycles, queue not full -> grants 0,1,0,1; four enqueues.
REQ-033 SHALL test full: queue at 8/8, req_valid[0]=1, out_ready=1 -> cycle 1 dequeue only, fifo_enque=0; cycle 2 grant 0 and enqueue.
REQ-034 SHALL test flush: inter_fail pulse in cycle 10 -> fifo_flush=1 cycles 10..14, no grants, RUN at 15, requester 0 first granted; flush_count=1 when QUE_SCHED_STATS_EN.
REQ-035 SHALL test lock: perm_fail and inter_fail together -> LOCK, locked=1, grants 0 for 20 cycles despite req_valid=all ones; rst -> locked=0 next cycle.
REQ-036 SHALL test pass-through: empty queue, one word 0xA5..A5 enqueued in cycle N, out_ready=1 -> out_valid=1 in cycle N+1, out_data=0xA5..A5, fifo_deque=1.
REQ-037 SHALL test rst in FLUSH cycle 2 -> RUN after reset, counter cleared, no extra FLUSH cycles.
